div_n_detector: RTL and testbench
=================================

DIV_N_DETECTOR -- requirements
Module: div_n_detector

Interface
REQ-001 The block SHALL have parameter DIVISOR, default 5, the divisor N; legal range 2..255.
REQ-002 The block SHALL have parameter IN_WIDTH, default 1, the number of bits shifted in per accepted beat; legal range 1..8.
REQ-003 The block SHALL have parameter CNT_WIDTH, default 16, the width of the beat counter.
REQ-004 The block SHALL derive localparam REM_WIDTH = $clog2(DIVISOR).
REQ-005 Port clk, input, 1: the single clock; all state SHALL update on its rising edge.
REQ-006 Port rst_n, input, 1: reset, synchronous and active-low.
REQ-007 Port in_valid, input, 1: in_data is accepted on this cycle; no backpressure, so every valid beat is consumed.
REQ-008 Port in_data, input, IN_WIDTH: next digit, MSB-first; in_data[IN_WIDTH-1] is the most significant bit of the digit.
REQ-009 Port clear, input, 1: synchronous restart of the running number.
REQ-010 Port div_n, output, 1: the running number is nonzero and divisible by DIVISOR.
REQ-011 Port remainder, output, REM_WIDTH: the running number mod DIVISOR.
REQ-012 Port nonzero_seen, output, 1: at least one nonzero digit has been accepted since reset or clear.
REQ-013 Port beat_count, output, CNT_WIDTH: the number of beats accepted since reset or clear, saturating.

Function
REQ-014 Running number definition: n_next = n * 2^IN_WIDTH + in_data on each accepted beat.
REQ-015 The block SHALL track only the remainder: rem_next = (rem * 2^IN_WIDTH + in_data) mod DIVISOR.
REQ-016 The remainder update SHALL be exact and complete within one cycle, with no multicycle paths.
REQ-017 The remainder register SHALL only ever hold values 0..DIVISOR-1.
REQ-018 Any intermediate width SHALL be at least REM_WIDTH+IN_WIDTH bits, with no truncation before the modulo.
REQ-019 Register states: the state is {rem, nonzero_seen, beat_count}, with two phases: IDLE (nonzero_seen=0) and TRACKING (nonzero_seen=1).
REQ-020 IDLE -> TRACKING SHALL occur on an accepted beat with in_data != 0; TRACKING -> IDLE SHALL occur only on clear or reset.
REQ-021 Outputs SHALL be Moore outputs and register-derived only: div_n = (remainder == 0) && nonzero_seen.
REQ-022 Latency: the outputs SHALL reflect a beat accepted at edge k from edge k onward (one cycle after presentation).
REQ-023 in_valid=0 and clear=0: all state SHALL hold.
REQ-024 clear=1, in_valid=0: rem=0, nonzero_seen=0, beat_count=0.
REQ-025 clear=1 and in_valid=1 in the same cycle: clear wins over the old state, and the beat SHALL be the first digit of a new number: rem = in_data mod DIVISOR, nonzero_seen = (in_data != 0), beat_count = 1.
REQ-026 beat_count SHALL increment per accepted beat and saturate at 2^CNT_WIDTH-1 without wrapping.
REQ-027 Saturation SHALL NOT affect remainder tracking.
REQ-028 Leading zero digits SHALL increment beat_count and leave rem=0 and div_n=0.
REQ-029 When DIVISOR is a power of two, the result SHALL still be correct, with no special-case behaviour visible at the ports.

Reset
REQ-030 While rst_n=0 at a rising edge: rem=0, nonzero_seen=0, beat_count=0, and therefore div_n=0; this takes priority over clear and in_valid.
REQ-031 Reset mid-stream SHALL discard the running number entirely.
REQ-032 The first beat accepted after rst_n rises SHALL start a new number.
REQ-033 Outputs SHALL be X-free from the first edge with rst_n=0, regardless of input values.

Verification
REQ-034 DIVISOR=5, IN_WIDTH=1, beats 1,0,1 -> remainder 1,2,0; div_n=1 after the 3rd beat; beat_count=3.
REQ-035 DIVISOR=7, IN_WIDTH=4, beats 0x1, 0x5 (n=21) -> remainder 1 then 0; div_n=1; then beat 0x0 (n=336=7*48) -> div_n stays 1.
REQ-036 DIVISOR=3, IN_WIDTH=2, five beats of 0 -> div_n=0, nonzero_seen=0, remainder=0, beat_count=5.
REQ-037 DIVISOR=5, IN_WIDTH=1: beats 1,1 (rem 3); then clear=1 with in_valid=1, in_data=1 -> rem=1, beat_count=1, nonzero_seen=1, div_n=0.
REQ-038 DIVISOR=5, IN_WIDTH=1: beats 1,0 (rem 2); then rst_n=0 for one edge with in_valid=1, in_data=1 -> all state zero; next beat 1 -> rem=1 (not 0).
REQ-039 CNT_WIDTH=3, 9 beats with in_valid gaps interleaved -> beat_count saturates at 7; remainder matches a reference model (n mod DIVISOR) on every beat; gaps hold all outputs.

Source files
------------

// File: rtl/div_n_detector.sv
// ---------------------------------------------------------------------------
// div_n_detector
//
// Purpose:
//   Watches a stream of digits, most significant digit first. Each accepted
//   beat appends IN_WIDTH bits to a running number
//   n_next = n * 2^IN_WIDTH + in_data. The block flags when that number is
//   nonzero and divisible by DIVISOR. Only n mod DIVISOR is stored, so the
//   stream can be as long as you like.
//
// Parameters:
//   DIVISOR   - divisor N, 2..255
//   IN_WIDTH  - bits per accepted beat, 1..8
//   CNT_WIDTH - width of the saturating beat counter
//
// Ports:
//   clk          - single clock; all state updates on its rising edge
//   rst_n        - synchronous, active-low reset; overrides clear and in_valid
//   in_valid     - in_data is consumed this cycle (there is no backpressure)
//   in_data      - next digit; in_data[IN_WIDTH-1] is its most significant bit
//   clear        - synchronous restart of the running number
//   div_n        - running number is nonzero and divisible by DIVISOR
//   remainder    - running number mod DIVISOR
//   nonzero_seen - a nonzero digit has been accepted since reset or clear
//   beat_count   - beats accepted since reset or clear, saturating
// ---------------------------------------------------------------------------
module div_n_detector #(
  parameter int DIVISOR   = 5,
  parameter int IN_WIDTH  = 1,
  parameter int CNT_WIDTH = 16,
  localparam int REM_WIDTH = $clog2(DIVISOR)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic [IN_WIDTH-1:0]  in_data,
  input  logic                 clear,
  output logic                 div_n,
  output logic [REM_WIDTH-1:0] remainder,
  output logic                 nonzero_seen,
  output logic [CNT_WIDTH-1:0] beat_count
);

  // Working width for the remainder update. It is wide enough for
  // rem * 2^IN_WIDTH + in_data, so nothing is truncated before the
  // reduction.
  localparam int STAGE_WIDTH = REM_WIDTH + IN_WIDTH;

  localparam logic [STAGE_WIDTH-1:0] DIV_CONST = STAGE_WIDTH'(DIVISOR);
  localparam logic [CNT_WIDTH-1:0]   CNT_MAX   = '1;

  // IDLE: only zero digits so far (or none). TRACKING: a nonzero digit was seen.
  typedef enum logic {
    IDLE     = 1'b0,
    TRACKING = 1'b1
  } phase_t;

  phase_t                 phase_reg,  phase_next;
  logic [REM_WIDTH-1:0]   rem_reg,    rem_next;
  logic [CNT_WIDTH-1:0]   cnt_reg,    cnt_next;
  logic                   div_reg,    div_next;

  // Starting state for this cycle's update. Clear behaves as if the old
  // number had never existed. A beat in the same cycle as clear therefore
  // becomes the first digit of a new number.
  logic [REM_WIDTH-1:0]   base_rem;
  phase_t                 base_phase;
  logic [CNT_WIDTH-1:0]   base_cnt;

  assign base_rem   = clear ? '0   : rem_reg;
  assign base_phase = clear ? IDLE : phase_reg;
  assign base_cnt   = clear ? '0   : cnt_reg;

  // -------------------------------------------------------------------------
  // Remainder update, one digit bit per stage.
  // Each stage does r = 2r + b and subtracts DIVISOR once if needed. The
  // incoming r is always below DIVISOR, so 2r + b <= 2*DIVISOR - 1. One
  // conditional subtract therefore brings it back to 0..DIVISOR-1. The chain
  // is IN_WIDTH compare/subtract steps long and fits in one cycle. It needs
  // no multiplier or divider and behaves the same for power-of-two divisors.
  // -------------------------------------------------------------------------
  logic [STAGE_WIDTH-1:0] stage [IN_WIDTH+1];

  assign stage[0] = STAGE_WIDTH'(base_rem);

  generate
    for (genvar gi = 0; gi < IN_WIDTH; gi++) begin : g_rem_stage
      logic [STAGE_WIDTH-1:0] shifted;

      // The digit is MSB-first, so stage gi takes bit IN_WIDTH-1-gi.
      assign shifted = (stage[gi] << 1) | STAGE_WIDTH'(in_data[IN_WIDTH-1-gi]);
      assign stage[gi+1] = (shifted >= DIV_CONST) ? (shifted - DIV_CONST) : shifted;
    end
  endgenerate

  logic [REM_WIDTH-1:0] rem_step;

  // The final stage is already below DIVISOR, so it fits in REM_WIDTH bits.
  assign rem_step = REM_WIDTH'(stage[IN_WIDTH]);

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    rem_next   = base_rem;
    phase_next = base_phase;
    cnt_next   = base_cnt;

    if (in_valid) begin
      rem_next = rem_step;
      if (in_data != '0) begin
        phase_next = TRACKING;
      end
      // Counter saturation leaves the remainder path alone.
      if (base_cnt != CNT_MAX) begin
        cnt_next = base_cnt + 1'b1;
      end
    end

    // div_n is registered. It is computed from the same next-state values
    // that the registers load, so it always matches remainder and nonzero_seen.
    div_next = (rem_next == '0) && (phase_next == TRACKING);
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase_reg <= IDLE;
      rem_reg   <= '0;
      cnt_reg   <= '0;
      div_reg   <= 1'b0;
    end else begin
      phase_reg <= phase_next;
      rem_reg   <= rem_next;
      cnt_reg   <= cnt_next;
      div_reg   <= div_next;
    end
  end

  assign div_n        = div_reg;
  assign remainder    = rem_reg;
  assign nonzero_seen = (phase_reg == TRACKING);
  assign beat_count   = cnt_reg;

endmodule

// File: tb/tb_div_n_detector.sv
// ---------------------------------------------------------------------------
// tb_div_n_detector
//
// Five instances share one clock and one stimulus bus. Each instance has its
// own parameter set. Each scenario task restarts the number it cares about
// and then checks only the instance under test:
//   u_a : DIVISOR=5, IN_WIDTH=1, CNT_WIDTH=16
//   u_b : DIVISOR=7, IN_WIDTH=4, CNT_WIDTH=16
//   u_c : DIVISOR=3, IN_WIDTH=2, CNT_WIDTH=16
//   u_d : DIVISOR=6, IN_WIDTH=3, CNT_WIDTH=3   (saturating counter)
//   u_e : DIVISOR=4, IN_WIDTH=2, CNT_WIDTH=16  (power-of-two divisor)
// ---------------------------------------------------------------------------
module tb_div_n_detector;

  logic       clk;
  logic       rst_n;
  logic       vld;
  logic       clr;
  logic [7:0] d_bus;

  int n_checks;
  int n_fails;

  logic        a_div, a_nz;  logic [2:0] a_rem;  logic [15:0] a_cnt;
  logic        b_div, b_nz;  logic [2:0] b_rem;  logic [15:0] b_cnt;
  logic        c_div, c_nz;  logic [1:0] c_rem;  logic [15:0] c_cnt;
  logic        d_div, d_nz;  logic [2:0] d_rem;  logic [2:0]  d_cnt;
  logic        e_div, e_nz;  logic [1:0] e_rem;  logic [15:0] e_cnt;

  div_n_detector #(.DIVISOR(5), .IN_WIDTH(1), .CNT_WIDTH(16)) u_a (
    .clk(clk), .rst_n(rst_n), .in_valid(vld), .in_data(d_bus[0:0]), .clear(clr),
    .div_n(a_div), .remainder(a_rem), .nonzero_seen(a_nz), .beat_count(a_cnt));

  div_n_detector #(.DIVISOR(7), .IN_WIDTH(4), .CNT_WIDTH(16)) u_b (
    .clk(clk), .rst_n(rst_n), .in_valid(vld), .in_data(d_bus[3:0]), .clear(clr),
    .div_n(b_div), .remainder(b_rem), .nonzero_seen(b_nz), .beat_count(b_cnt));

  div_n_detector #(.DIVISOR(3), .IN_WIDTH(2), .CNT_WIDTH(16)) u_c (
    .clk(clk), .rst_n(rst_n), .in_valid(vld), .in_data(d_bus[1:0]), .clear(clr),
    .div_n(c_div), .remainder(c_rem), .nonzero_seen(c_nz), .beat_count(c_cnt));

  div_n_detector #(.DIVISOR(6), .IN_WIDTH(3), .CNT_WIDTH(3)) u_d (
    .clk(clk), .rst_n(rst_n), .in_valid(vld), .in_data(d_bus[2:0]), .clear(clr),
    .div_n(d_div), .remainder(d_rem), .nonzero_seen(d_nz), .beat_count(d_cnt));

  div_n_detector #(.DIVISOR(4), .IN_WIDTH(2), .CNT_WIDTH(16)) u_e (
    .clk(clk), .rst_n(rst_n), .in_valid(vld), .in_data(d_bus[1:0]), .clear(clr),
    .div_n(e_div), .remainder(e_rem), .nonzero_seen(e_nz), .beat_count(e_cnt));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Presents one cycle of stimulus. Inputs change on the falling edge. The
  // task returns 1 ns after the rising edge that samples them, which is when
  // the outputs are checked, and then returns the inputs to idle.
  task automatic drive(input logic r, input logic v, input logic c, input logic [7:0] d);
    @(negedge clk);
    rst_n = r;
    vld   = v;
    clr   = c;
    d_bus = d;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    vld   = 1'b0;
    clr   = 1'b0;
    d_bus = 8'h00;
  endtask

  task automatic test_reset;
    // Reset wins over clear and a valid beat that arrive in the same cycle.
    drive(1'b0, 1'b1, 1'b1, 8'hFF);
    n_checks++; if (a_rem !== 3'd0)  begin n_fails++; $display("FAIL reset_a_rem: got %0d expected 0", a_rem); end
    n_checks++; if (a_div !== 1'b0)  begin n_fails++; $display("FAIL reset_a_div: got %0d expected 0", a_div); end
    n_checks++; if (a_nz  !== 1'b0)  begin n_fails++; $display("FAIL reset_a_nz: got %0d expected 0", a_nz); end
    n_checks++; if (a_cnt !== 16'd0) begin n_fails++; $display("FAIL reset_a_cnt: got %0d expected 0", a_cnt); end
    n_checks++; if (b_rem !== 3'd0)  begin n_fails++; $display("FAIL reset_b_rem: got %0d expected 0", b_rem); end
    n_checks++; if (d_cnt !== 3'd0)  begin n_fails++; $display("FAIL reset_d_cnt: got %0d expected 0", d_cnt); end
    $display("test_reset: rem=%0d div=%0d nz=%0d cnt=%0d", a_rem, a_div, a_nz, a_cnt);
  endtask

  task automatic test_binary;
    logic       dig   [3] = '{1'b1, 1'b0, 1'b1};
    logic [2:0] exp_r [3] = '{3'd1, 3'd2, 3'd0};
    logic       exp_d [3] = '{1'b0, 1'b0, 1'b1};
    drive(1'b1, 1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 1'b0, {7'd0, dig[i]});
      n_checks++; if (a_rem !== exp_r[i]) begin n_fails++; $display("FAIL binary_rem[%0d]: got %0d expected %0d", i, a_rem, exp_r[i]); end
      n_checks++; if (a_div !== exp_d[i]) begin n_fails++; $display("FAIL binary_div[%0d]: got %0d expected %0d", i, a_div, exp_d[i]); end
      $display("test_binary: beat %0d digit=%0d rem=%0d div=%0d", i, dig[i], a_rem, a_div);
    end
    n_checks++; if (a_cnt !== 16'd3) begin n_fails++; $display("FAIL binary_cnt: got %0d expected 3", a_cnt); end
  endtask

  task automatic test_hex;
    logic [3:0] dig   [3] = '{4'h1, 4'h5, 4'h0};
    logic [2:0] exp_r [3] = '{3'd1, 3'd0, 3'd0};
    logic       exp_d [3] = '{1'b0, 1'b1, 1'b1};
    drive(1'b1, 1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 1'b0, {4'd0, dig[i]});
      n_checks++; if (b_rem !== exp_r[i]) begin n_fails++; $display("FAIL hex_rem[%0d]: got %0d expected %0d", i, b_rem, exp_r[i]); end
      n_checks++; if (b_div !== exp_d[i]) begin n_fails++; $display("FAIL hex_div[%0d]: got %0d expected %0d", i, b_div, exp_d[i]); end
      $display("test_hex: beat %0d digit=%0h rem=%0d div=%0d", i, dig[i], b_rem, b_div);
    end
  endtask

  task automatic test_leading_zeros;
    drive(1'b1, 1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b1, 1'b0, 8'h00);
      n_checks++; if (c_div !== 1'b0) begin n_fails++; $display("FAIL zeros_div[%0d]: got %0d expected 0", i, c_div); end
      $display("test_leading_zeros: beat %0d rem=%0d div=%0d cnt=%0d", i, c_rem, c_div, c_cnt);
    end
    n_checks++; if (c_nz  !== 1'b0)  begin n_fails++; $display("FAIL zeros_nz: got %0d expected 0", c_nz); end
    n_checks++; if (c_rem !== 2'd0)  begin n_fails++; $display("FAIL zeros_rem: got %0d expected 0", c_rem); end
    n_checks++; if (c_cnt !== 16'd5) begin n_fails++; $display("FAIL zeros_cnt: got %0d expected 5", c_cnt); end
  endtask

  task automatic test_clear;
    drive(1'b1, 1'b0, 1'b1, 8'h00);
    drive(1'b1, 1'b1, 1'b0, 8'h01);
    drive(1'b1, 1'b1, 1'b0, 8'h01);
    n_checks++; if (a_rem !== 3'd3) begin n_fails++; $display("FAIL clear_pre_rem: got %0d expected 3", a_rem); end
    $display("test_clear: before clear rem=%0d cnt=%0d", a_rem, a_cnt);
    // Clear and a beat in the same cycle start a new number with that digit.
    drive(1'b1, 1'b1, 1'b1, 8'h01);
    n_checks++; if (a_rem !== 3'd1)  begin n_fails++; $display("FAIL clear_beat_rem: got %0d expected 1", a_rem); end
    n_checks++; if (a_cnt !== 16'd1) begin n_fails++; $display("FAIL clear_beat_cnt: got %0d expected 1", a_cnt); end
    n_checks++; if (a_nz  !== 1'b1)  begin n_fails++; $display("FAIL clear_beat_nz: got %0d expected 1", a_nz); end
    n_checks++; if (a_div !== 1'b0)  begin n_fails++; $display("FAIL clear_beat_div: got %0d expected 0", a_div); end
    $display("test_clear: clear+beat rem=%0d cnt=%0d nz=%0d div=%0d", a_rem, a_cnt, a_nz, a_div);
    // A clear with no beat empties everything.
    drive(1'b1, 1'b0, 1'b1, 8'h01);
    n_checks++; if (a_rem !== 3'd0)  begin n_fails++; $display("FAIL clear_only_rem: got %0d expected 0", a_rem); end
    n_checks++; if (a_cnt !== 16'd0) begin n_fails++; $display("FAIL clear_only_cnt: got %0d expected 0", a_cnt); end
    n_checks++; if (a_nz  !== 1'b0)  begin n_fails++; $display("FAIL clear_only_nz: got %0d expected 0", a_nz); end
    $display("test_clear: clear only rem=%0d cnt=%0d nz=%0d", a_rem, a_cnt, a_nz);
  endtask

  task automatic test_reset_mid_stream;
    drive(1'b1, 1'b0, 1'b1, 8'h00);
    drive(1'b1, 1'b1, 1'b0, 8'h01);
    drive(1'b1, 1'b1, 1'b0, 8'h00);
    n_checks++; if (a_rem !== 3'd2) begin n_fails++; $display("FAIL midrst_pre_rem: got %0d expected 2", a_rem); end
    drive(1'b0, 1'b1, 1'b0, 8'h01);
    n_checks++; if (a_rem !== 3'd0)  begin n_fails++; $display("FAIL midrst_rem: got %0d expected 0", a_rem); end
    n_checks++; if (a_cnt !== 16'd0) begin n_fails++; $display("FAIL midrst_cnt: got %0d expected 0", a_cnt); end
    n_checks++; if (a_nz  !== 1'b0)  begin n_fails++; $display("FAIL midrst_nz: got %0d expected 0", a_nz); end
    $display("test_reset_mid_stream: in reset rem=%0d cnt=%0d nz=%0d", a_rem, a_cnt, a_nz);
    drive(1'b1, 1'b1, 1'b0, 8'h01);
    n_checks++; if (a_rem !== 3'd1)  begin n_fails++; $display("FAIL midrst_post_rem: got %0d expected 1", a_rem); end
    n_checks++; if (a_cnt !== 16'd1) begin n_fails++; $display("FAIL midrst_post_cnt: got %0d expected 1", a_cnt); end
    $display("test_reset_mid_stream: after reset rem=%0d cnt=%0d", a_rem, a_cnt);
  endtask

  task automatic test_saturation;
    logic [2:0] dig [9] = '{3'd3, 3'd0, 3'd5, 3'd7, 3'd2, 3'd6, 3'd1, 3'd4, 3'd3};
    int  m_rem;
    int  m_cnt;
    logic m_nz;
    logic m_div;
    m_rem = 0; m_cnt = 0; m_nz = 1'b0;
    drive(1'b1, 1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, 1'b1, 1'b0, {5'd0, dig[i]});
      m_rem = (m_rem * 8 + int'(dig[i])) % 6;
      m_cnt = (m_cnt < 7) ? m_cnt + 1 : 7;
      m_nz  = m_nz | (dig[i] != 3'd0);
      m_div = (m_rem == 0) && m_nz;
      n_checks++; if (d_rem !== 3'(m_rem)) begin n_fails++; $display("FAIL sat_rem[%0d]: got %0d expected %0d", i, d_rem, m_rem); end
      n_checks++; if (d_cnt !== 3'(m_cnt)) begin n_fails++; $display("FAIL sat_cnt[%0d]: got %0d expected %0d", i, d_cnt, m_cnt); end
      n_checks++; if (d_div !== m_div)     begin n_fails++; $display("FAIL sat_div[%0d]: got %0d expected %0d", i, d_div, m_div); end
      $display("test_saturation: beat %0d digit=%0d rem=%0d cnt=%0d div=%0d", i, dig[i], d_rem, d_cnt, d_div);
      // Gap cycle: data changes but is not valid, so nothing may move.
      drive(1'b1, 1'b0, 1'b0, 8'h05);
      n_checks++; if (d_rem !== 3'(m_rem)) begin n_fails++; $display("FAIL gap_rem[%0d]: got %0d expected %0d", i, d_rem, m_rem); end
      n_checks++; if (d_cnt !== 3'(m_cnt)) begin n_fails++; $display("FAIL gap_cnt[%0d]: got %0d expected %0d", i, d_cnt, m_cnt); end
      n_checks++; if (d_nz  !== m_nz)      begin n_fails++; $display("FAIL gap_nz[%0d]: got %0d expected %0d", i, d_nz, m_nz); end
    end
  endtask

  task automatic test_pow2;
    logic [1:0] dig   [4] = '{2'd1, 2'd3, 2'd2, 2'd0};
    logic [1:0] exp_r [4] = '{2'd1, 2'd3, 2'd2, 2'd0};  // n = 1, 7, 30, 120
    logic       exp_d [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    drive(1'b1, 1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, 1'b0, {6'd0, dig[i]});
      n_checks++; if (e_rem !== exp_r[i]) begin n_fails++; $display("FAIL pow2_rem[%0d]: got %0d expected %0d", i, e_rem, exp_r[i]); end
      n_checks++; if (e_div !== exp_d[i]) begin n_fails++; $display("FAIL pow2_div[%0d]: got %0d expected %0d", i, e_div, exp_d[i]); end
      $display("test_pow2: beat %0d digit=%0d rem=%0d div=%0d", i, dig[i], e_rem, e_div);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    rst_n    = 1'b0;
    vld      = 1'b0;
    clr      = 1'b0;
    d_bus    = 8'h00;
    test_reset();
    test_binary();
    test_hex();
    test_leading_zeros();
    test_clear();
    test_reset_mid_stream();
    test_saturation();
    test_pow2();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
